// File: rtl/load_store_unit.sv
// Load/store unit: one data-bus transaction per core memory op, with store lane steering and load alignment/extension.
// Optional macro LSU_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES cycles in REQ/WAIT.

package riscv_pkg;
  parameter int unsigned XLEN = 32;
endpackage

module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_sign_ext_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic            lsu_misaligned_o,
  output logic            lsu_err_o,
  output logic            bus_req_o,
  input  logic            bus_gnt_i,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wd);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rd, input logic [1:0] off,
                                                  input logic [1:0] size, input logic sign);
    logic [XLEN-1:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{sign & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{sign & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            stall_s;
  logic            misaligned_s;
  logic            bad_align_s;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_s;
`endif

  // Illegal size or an address not aligned to the access size
  always_comb begin
    case (lsu_size_i)
      2'b00:   bad_align_s = 1'b0;
      2'b01:   bad_align_s = lsu_addr_i[0];
      2'b10:   bad_align_s = (lsu_addr_i[1:0] != 2'b00);
      default: bad_align_s = 1'b1;
    endcase
  end

  // Next-state, bus setup and response capture
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    sign_d       = sign_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    stall_s      = 1'b0;
    misaligned_s = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    expire_s     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i && bad_align_s) begin
          misaligned_s = 1'b1;
        end else if (lsu_req_i) begin
          stall_s = 1'b1;
          addr_d  = {lsu_addr_i[XLEN-1:2], 2'b00};
          we_d    = lsu_we_i;
          be_d    = lane_be(lsu_size_i, lsu_addr_i[1:0]);
          wdata_d = lsu_we_i ? lane_wdata(lsu_size_i, lsu_wdata_i) : {XLEN{1'b0}};
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          sign_d  = lsu_sign_ext_i;
          state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        stall_s = 1'b1;
        // Response counts only once the grant has been seen
        if ((state_q == S_WAIT || bus_gnt_i) && bus_rvalid_i) begin
          rdata_d = we_q ? {XLEN{1'b0}} : load_extend(bus_rdata_i, off_q, size_q, sign_q);
          state_d = S_DONE;
        end else if (state_q == S_REQ && bus_gnt_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = state_q;
        end
`ifdef LSU_TIMEOUT_EN
        if (state_d != S_DONE && expire_s) begin
          rdata_d = {XLEN{1'b0}};
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b0;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {XLEN{1'b0}};
      be_q    <= 4'b0000;
      wdata_q <= {XLEN{1'b0}};
      rdata_q <= {XLEN{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Cycles spent in REQ/WAIT for the current transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign lsu_err_o = err_q;
`else
  assign lsu_err_o = 1'b0;
`endif

  assign lsu_rdata_o      = rdata_q;
  assign lsu_stall_o      = stall_s;
  assign lsu_done_o       = (state_q == S_DONE);
  assign lsu_misaligned_o = misaligned_s;
  assign bus_req_o        = (state_q == S_REQ);
  assign bus_we_o         = we_q;
  assign bus_addr_o       = addr_q;
  assign bus_be_o         = be_q;
  assign bus_wdata_o      = wdata_q;

endmodule
